// File: rtl/sm_to_tc_decoder.sv
// -----------------------------------------------------------------------------
// sm_to_tc_decoder
//
// Purpose:
//   Streaming converter from a sign/magnitude result (separate sign bit plus
//   unsigned magnitude) to the equivalent two's-complement word for the
//   accumulator/readout chain. Valid/ready handshakes on both sides run at
//   full throughput. A two-entry buffer (output register plus one skid entry)
//   keeps in_ready a pure register that never looks at out_ready.
//   Negative-zero inputs (sign=1, mag=0) produce out_data=0. They are flagged
//   on out_negzero and can be counted.
//
// Optional feature (compile-time macro):
//   SMTC_NEGZERO_CNT_EN - when defined, nz_count is a saturating count of
//                         accepted negative-zero inputs, cleared by cnt_clr.
//                         When undefined, nz_count is tied to 0 and cnt_clr
//                         is ignored.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   upstream word valid
//   in_ready     out  block can accept a word (registered)
//   in_sign      in   sign of the result (1 = negative)
//   in_mag       in   [MAG_W-1:0] unsigned magnitude
//   out_valid    out  out_data valid
//   out_ready    in   downstream accepts
//   out_data     out  [MAG_W:0] two's-complement result
//   out_negzero  out  current out_data came from a negative-zero input
//   cnt_clr      in   synchronous clear of nz_count
//   nz_count     out  [CNT_W-1:0] saturating negative-zero count
// -----------------------------------------------------------------------------
module sm_to_tc_decoder #(
  parameter int MAG_W = 15,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [MAG_W-1:0] in_mag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAG_W:0]   out_data,
  output logic             out_negzero,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] nz_count
);

  logic             accept;
  logic             consume;
  logic [MAG_W:0]   inWord;
  logic [MAG_W:0]   convData;
  logic             convNz;

  logic             inReady_q,  inReady_d;
  logic             outValid_q, outValid_d;
  logic [MAG_W:0]   outData_q,  outData_d;
  logic             outNz_q,    outNz_d;
  logic             skidValid_q, skidValid_d;
  logic [MAG_W:0]   skidData_q,  skidData_d;
  logic             skidNz_q,    skidNz_d;

  assign accept  = in_valid && inReady_q;
  assign consume = outValid_q && out_ready;

  // The magnitude is zero-extended by one bit, so negating it can never
  // overflow: the largest magnitude 2^MAG_W-1 still fits as a negative value.
  assign inWord   = {1'b0, in_mag};
  assign convData = in_sign ? -inWord : inWord;
  assign convNz   = in_sign && (in_mag == '0);

  // Buffer control. The output register refills whenever it is empty or being
  // drained: the skid entry has priority, since it holds the older word. The
  // skid entry can only be full while in_ready is low, so an accept and a
  // skid-to-output move never coincide.
  always_comb begin
    inReady_d   = inReady_q;
    outValid_d  = outValid_q;
    outData_d   = outData_q;
    outNz_d     = outNz_q;
    skidValid_d = skidValid_q;
    skidData_d  = skidData_q;
    skidNz_d    = skidNz_q;
    if (!outValid_q || consume) begin
      if (skidValid_q) begin
        outValid_d  = 1'b1;
        outData_d   = skidData_q;
        outNz_d     = skidNz_q;
        skidValid_d = 1'b0;
        inReady_d   = 1'b1;
      end else if (accept) begin
        outValid_d = 1'b1;
        outData_d  = convData;
        outNz_d    = convNz;
      end else begin
        outValid_d = 1'b0;
      end
    end else if (accept) begin
      skidValid_d = 1'b1;
      skidData_d  = convData;
      skidNz_d    = convNz;
      inReady_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inReady_q   <= 1'b1;
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      outNz_q     <= 1'b0;
      skidValid_q <= 1'b0;
      skidData_q  <= '0;
      skidNz_q    <= 1'b0;
    end else begin
      inReady_q   <= inReady_d;
      outValid_q  <= outValid_d;
      outData_q   <= outData_d;
      outNz_q     <= outNz_d;
      skidValid_q <= skidValid_d;
      skidData_q  <= skidData_d;
      skidNz_q    <= skidNz_d;
    end
  end

  assign in_ready    = inReady_q;
  assign out_valid   = outValid_q;
  assign out_data    = outData_q;
  assign out_negzero = outNz_q;

`ifdef SMTC_NEGZERO_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [CNT_W-1:0] nzCount_q, nzCount_d;

  // Counts negative-zero words at the moment they are accepted, not when they
  // leave. The clear wins over a simultaneous increment.
  always_comb begin
    nzCount_d = nzCount_q;
    if (cnt_clr) begin
      nzCount_d = '0;
    end else if (accept && convNz && (nzCount_q != '1)) begin
      nzCount_d = nzCount_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nzCount_q <= '0;
    end else begin
      nzCount_q <= nzCount_d;
    end
  end

  assign nz_count = nzCount_q;
`else
  logic unusedCntClr;
  assign unusedCntClr = cnt_clr;
  assign nz_count     = '0;
`endif

endmodule

// File: doc/sm_to_tc_decoder.md
Name: sm_to_tc_decoder

Overview:
- Streaming decoder from sign-magnitude to two's complement. It is the inverse path of the PE sign/magnitude datapath.
- Each PE result arrives as a separate sign bit plus an unsigned magnitude. The block emits the equivalent two's-complement word for the accumulator/readout chain.
- Valid/ready on both sides, full throughput, registered in_ready via a 2-entry skid buffer.
- Flags and counts negative-zero results (sign=1, mag=0).

Parameters:
- MAG_W, 15, magnitude width. The output word is MAG_W+1 bits.
- CNT_W, 8, width of the negative-zero event counter.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream word valid
- in_ready  output  1  block can accept a word. Registered.
- in_sign  input  1  sign of the result (1 = negative)
- in_mag  input  MAG_W  unsigned magnitude
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts
- out_data  output  MAG_W+1  two's-complement result
- out_negzero  output  1  current out_data came from a negative-zero input
- cnt_clr  input  1  synchronous clear of nz_count
- nz_count  output  CNT_W  saturating count of accepted negative-zero inputs

Behaviour:
- Reset (async assert, sync release) values: in_ready=1, out_valid=0, out_data=0, out_negzero=0, nz_count=0, skid empty.
- Input handshake: a word is accepted on a rising edge where in_valid && in_ready.
- Output handshake: a word is consumed on a rising edge where out_valid && out_ready.
- out_data, out_valid and out_negzero are held stable while out_valid && !out_ready.
- Conversion:
  - sign=0: out_data = {1'b0, mag}.
  - sign=1: out_data = two's-complement negation of {1'b0, mag}.
  - No overflow is possible, since |min| = 2^MAG_W-1.
- Negative zero: sign=1, mag=0 gives out_data=0 and out_negzero=1. All other inputs give out_negzero=0.
- Latency: a word accepted at edge N is on the outputs after edge N (out_valid visible in cycle N+1), provided the output register is empty or is being consumed at edge N.
- Storage: one output register plus one skid entry, 2 words total.
  - Skid state: the output register is occupied, is not consumed at an edge, and a word is accepted at that same edge. The new word goes to the skid entry and in_ready goes low after that edge.
  - When the output is consumed and the skid entry is full: skid moves to the output register at that edge, and in_ready returns high after the edge.
- Simultaneous accept and consume with the skid empty: the output register is replaced by the new word and out_valid stays 1.
- in_ready is a pure register and does not depend combinationally on out_ready.
- Order is strictly FIFO. No word is dropped or duplicated.
- nz_count:
  - Increments by 1 on each accepted negative-zero input.
  - Saturates at 2^CNT_W-1.
  - cnt_clr has priority: a clear and an increment at the same edge leave 0.
- Reset mid-stream: all buffered words are discarded and the block returns to the reset values.

Optional Feature:
- Macro: SMTC_NEGZERO_CNT_EN.
- Defined: nz_count and cnt_clr behave as described above.
- Not defined: the counter logic is removed, nz_count is tied to 0, and cnt_clr is ignored.
- out_negzero is present in both builds.

Test Plan (MAG_W=7, CNT_W=8):
- Reset with in_valid=1 asserted mid-transfer -> in_ready=1, out_valid=0, out_data=0x00 while rst_n=0; no word emitted after release until a new accept.
- out_ready=1 held; feed (0,5), (1,5), (1,127), (0,127) back-to-back.
  - Outputs are 0x05, 0xFB, 0x81, 0x7F on consecutive cycles, each 1 cycle after accept.
  - in_ready stays 1 throughout.
- Feed (1,0) -> out_data=0x00, out_negzero=1, nz_count=1 (macro defined) or 0 (not defined).
- out_ready=0; feed (0,1), (0,2), (0,3).
  - in_ready drops after the 2nd accept, so the 3rd word is held upstream.
  - Raise out_ready -> outputs 0x01, 0x02, 0x03 in order, with none lost.
- Send 256 negative-zero words -> nz_count saturates at 255.
- Assert cnt_clr in the same cycle as a negative-zero accept -> nz_count=0.
- Random valid/ready toggling over 10k words, scoreboard against a software conversion -> exact match, in order.
